// File: rtl/quat_bitri_rx.sv
// quat_bitri_rx: clocked NCL quaternary receiver that splits each DATA wavefront into binary and trinary digits behind a FIFO
module quat_bitri_rx #(
    parameter int DEPTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     init_n,
    input  logic [3:0]               quat_in,
    output logic                     quat_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_quat,
    output logic                     out_bi,
    output logic [1:0]               out_tri,
    output logic                     err_multi,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;

    typedef enum logic [1:0] {WAIT_NULL, WAIT_DATA, HOLD_FULL} state_t;

    logic [3:0]         r_sync [SYNC_STAGES];
    logic [SYNC_STAGES:0] r_pv;
    logic [3:0]         r_last;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_held;
    state_t             r_state;
    state_t             w_next;
    logic               r_ack;
    logic               r_err_multi;
    logic [7:0]         r_err_cnt;
    logic [1:0]         r_mem [DEPTH];
    logic [AW:0]        r_wp;
    logic [AW:0]        r_rp;

    logic [3:0]         w_word;
    logic               w_same;
    logic               w_stable;
    logic               w_onehot;
    logic               w_multi;
    logic [1:0]         w_q;
    logic [AW:0]        w_level;
    logic               w_full;
    logic               w_pop;
    logic               w_room;
    logic               w_push;
    logic               w_err;

    // r_pv marks which pipeline positions hold real samples, so reset zeros never count as a stable NULL
    assign w_word   = r_sync[SYNC_STAGES-1];
    assign w_same   = r_pv[SYNC_STAGES] && (w_word == r_last);
    assign w_stable = w_same && (r_cnt == CW'(STABLE_CYCLES - 1));
    assign w_onehot = (w_word != 4'd0) && ((w_word & (w_word - 4'd1)) == 4'd0);
    assign w_multi  = (w_word != 4'd0) && !w_onehot;
    assign w_q      = {w_word[3] | w_word[2], w_word[3] | w_word[1]};
    assign w_level  = r_wp - r_rp;
    assign w_full   = w_level == (AW+1)'(DEPTH);
    assign w_pop    = out_valid && out_ready;
    assign w_room   = !w_full || w_pop;

    // Per-rail synchronizer chain plus sample-validity shift
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'd0;
            r_pv <= '0;
        end else begin
            r_sync[0] <= quat_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_pv <= {r_pv[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Stability counter: restarts whenever the synced word changes
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_last <= 4'd0;
            r_cnt  <= '0;
        end else begin
            r_last <= w_word;
            r_cnt  <= !w_same ? '0 : (r_cnt == CW'(STABLE_CYCLES - 1)) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // Handshake FSM next-state, push and error decisions
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            WAIT_NULL: w_next = (w_stable && w_word == 4'd0) ? WAIT_DATA : WAIT_NULL;
            WAIT_DATA: begin
                if (w_stable && w_word != 4'd0) begin
                    w_err  = w_multi;
                    w_push = !w_multi && w_room;
                    w_next = (w_multi || w_room) ? WAIT_NULL : HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (w_word != r_held) begin
                    w_next = WAIT_DATA;
                end else if (w_room) begin
                    w_push = 1'b1;
                    w_next = WAIT_NULL;
                end
            end
            default: w_next = WAIT_NULL;
        endcase
    end

    // State, registered ack, held wavefront and error tracking
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state     <= WAIT_NULL;
            r_ack       <= 1'b1;
            r_held      <= 4'd0;
            r_err_multi <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_ack       <= w_next == WAIT_NULL;
            r_held      <= (r_state == WAIT_DATA) ? w_word : r_held;
            r_err_multi <= r_err_multi | w_err;
            r_err_cnt   <= (w_err && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
        end
    end

    // Output FIFO storing the quaternary value; pointers carry an extra wrap bit
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'd0;
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_mem[r_wp[AW-1:0]] <= w_q;
            r_wp <= r_wp + (AW+1)'(w_push);
            r_rp <= r_rp + (AW+1)'(w_pop);
        end
    end

    assign quat_ack   = r_ack;
    assign out_valid  = w_level != '0;
    assign out_quat   = r_mem[r_rp[AW-1:0]];
    assign out_bi     = &out_quat;
    assign out_tri    = out_bi ? 2'd2 : out_quat;
    assign err_multi  = r_err_multi;
    assign err_count  = r_err_cnt;
    assign fifo_level = w_level;
endmodule

// File: tb/tb_quat_bitri_rx.sv
// tb_quat_bitri_rx: table-driven and scoreboard checks for the quaternary receiver
module tb_quat_bitri_rx;
    typedef struct {
        logic [3:0] rails;
        int         q;
        int         b;
        int         t;
    } vec_t;

    logic       clk = 1'b0;
    logic       init_n;
    logic [3:0] quat_in;
    logic       quat_ack;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_quat;
    logic       out_bi;
    logic [1:0] out_tri;
    logic       err_multi;
    logic [7:0] err_count;
    logic [2:0] fifo_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tv [4];
    vec_t sb [$];

    quat_bitri_rx #(.DEPTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(2)) dut (
        .clk(clk), .init_n(init_n), .quat_in(quat_in), .quat_ack(quat_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_quat(out_quat),
        .out_bi(out_bi), .out_tri(out_tri), .err_multi(err_multi),
        .err_count(err_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input logic v, input string nm);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (quat_ack == v) break;
        end
        check(nm, int'(quat_ack), int'(v));
    endtask

    task automatic send(input logic [3:0] rails);
        quat_in = rails;
        wait_ack(1'b1, "ack_rise");
        quat_in = 4'd0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (init_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("pop_quat", int'(out_quat), e.q);
                check("pop_bi", int'(out_bi), e.b);
                check("pop_tri", int'(out_tri), e.t);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{4'b0001, 0, 0, 0};
        tv[1] = '{4'b0010, 1, 0, 1};
        tv[2] = '{4'b0100, 2, 0, 2};
        tv[3] = '{4'b1000, 3, 1, 2};

        init_n = 1'b0; quat_in = 4'b0100; out_ready = 1'b0;
        clocks(3);
        check("rst_ack", int'(quat_ack), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_err_multi", int'(err_multi), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_quat", int'(out_quat), 0);
        init_n = 1'b1;
        clocks(8);
        check("hold_wait_null_ack", int'(quat_ack), 1);
        check("hold_wait_null_valid", int'(out_valid), 0);
        quat_in = 4'd0;
        wait_ack(1'b0, "first_null");

        sb.push_back(tv[3]);
        quat_in = 4'b1000;
        clocks(4);
        check("lat4_valid", int'(out_valid), 0);
        check("lat4_ack", int'(quat_ack), 0);
        clocks(1);
        check("lat5_valid", int'(out_valid), 1);
        check("lat5_ack", int'(quat_ack), 1);
        check("lat5_quat", int'(out_quat), 3);
        check("lat5_bi", int'(out_bi), 1);
        check("lat5_tri", int'(out_tri), 2);
        check("lat5_level", int'(fifo_level), 1);
        quat_in = 4'd0;
        clocks(3);
        check("null3_ack", int'(quat_ack), 1);
        clocks(2);
        check("null5_ack", int'(quat_ack), 0);
        out_ready = 1'b1;
        clocks(1);
        out_ready = 1'b0;
        check("single_drained", int'(fifo_level), 0);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(tv[i]);
            send(tv[i].rails);
        end
        clocks(2);
        check("sweep_err_multi", int'(err_multi), 0);
        check("sweep_sb_empty", sb.size(), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(tv[i]);
            send(tv[i].rails);
        end
        check("full_level", int'(fifo_level), 4);
        sb.push_back(tv[1]);
        quat_in = tv[1].rails;
        clocks(10);
        check("hold_full_ack", int'(quat_ack), 0);
        check("hold_full_level", int'(fifo_level), 4);
        out_ready = 1'b1;
        clocks(1);
        out_ready = 1'b0;
        check("hold_release_level", int'(fifo_level), 4);
        check("hold_release_ack", int'(quat_ack), 1);
        quat_in = 4'd0;
        wait_ack(1'b0, "hold_null");
        out_ready = 1'b1;
        clocks(6);
        check("drain_level", int'(fifo_level), 0);
        check("drain_sb_empty", sb.size(), 0);

        send(4'b0011);
        check("multi_err_multi", int'(err_multi), 1);
        check("multi_err_count", int'(err_count), 1);
        check("multi_no_push", int'(fifo_level), 0);
        for (int i = 0; i < 255; i++) send(4'b0011);
        check("multi_err_sat254", int'(err_count), 255);
        send(4'b1100);
        check("multi_err_sat", int'(err_count), 255);

        quat_in = 4'b0100;
        clocks(1);
        quat_in = 4'd0;
        clocks(10);
        check("glitch_ack", int'(quat_ack), 0);
        check("glitch_level", int'(fifo_level), 0);

        out_ready = 1'b0;
        send(tv[2].rails);
        check("pre_reset_level", int'(fifo_level), 1);
        quat_in = 4'b0010;
        clocks(3);
        #2 init_n = 1'b0;
        #1;
        check("async_rst_ack", int'(quat_ack), 1);
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_level", int'(fifo_level), 0);
        check("async_rst_err_multi", int'(err_multi), 0);
        check("async_rst_err_count", int'(err_count), 0);
        check("async_rst_quat", int'(out_quat), 0);
        clocks(1);
        init_n = 1'b1;
        quat_in = 4'd0;
        wait_ack(1'b0, "recover_null");
        out_ready = 1'b1;
        sb.push_back(tv[1]);
        send(tv[1].rails);
        clocks(2);
        check("final_level", int'(fifo_level), 0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
